// File: rtl/masked_sbox_sequencer.sv
// Byte-serial masked SubBytes/InvSubBytes sequencer for an area-optimised AES core.
// One shared combinational masked S-box; fresh LFSR output mask per byte.

module sbox_masked_canright (
  input  logic [7:0] a,
  input  logic [7:0] m,
  input  logic [7:0] n,
  input  logic       encrypt,
  output logic [7:0] q
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int k = 0; k < 8; k++) begin
      if (y[k]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] s;
    logic [7:0] r;
    s = x;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  logic [7:0] x;
  assign x = a ^ m;
  assign q = (encrypt ? affine(gf_inv(x)) : gf_inv(inv_affine(x))) ^ n;
endmodule

// state | meaning
// IDLE  | waiting for an input state, seed loads honoured
// RUN   | one byte per cycle through the S-box, LFSR advances
// DRAIN | PIPE=1 only: writes the last registered byte
// DONE  | result held with out_valid until out_ready
module masked_sbox_sequencer #(
  parameter bit          PIPE       = 1'b0,
  parameter logic [15:0] RESET_SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         encrypt,
  input  logic [127:0] in_data,
  input  logic [127:0] in_mask,
  input  logic         seed_load,
  input  logic [15:0]  seed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [127:0] out_mask,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t       state;
  logic [3:0]   cnt;
  logic [15:0]  lfsr;
  logic         enc_q;
  logic [127:0] data_q;
  logic [127:0] mask_q;
  logic [7:0]   q_pipe;
  logic [7:0]   n_pipe;
  logic [3:0]   idx_pipe;
  logic         pend;
  logic [7:0]   sb_a;
  logic [7:0]   sb_m;
  logic [7:0]   sb_n;
  logic [7:0]   sb_q;
  logic [15:0]  lfsr_next;
  logic [15:0]  seed_eff;

  assign sb_a      = data_q[{cnt, 3'b000} +: 8];
  assign sb_m      = mask_q[{cnt, 3'b000} +: 8];
  assign sb_n      = lfsr[7:0];
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  // A zero seed would lock the LFSR, so it is replaced by the reset seed.
  assign seed_eff  = (seed == 16'h0000) ? RESET_SEED : seed;
  assign in_ready  = (state == IDLE) && rst_n;

  sbox_masked_canright u_sbox (
    .a       (sb_a),
    .m       (sb_m),
    .n       (sb_n),
    .encrypt (enc_q),
    .q       (sb_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lfsr      <= RESET_SEED;
      enc_q     <= 1'b0;
      data_q    <= '0;
      mask_q    <= '0;
      q_pipe    <= 8'h00;
      n_pipe    <= 8'h00;
      idx_pipe  <= 4'd0;
      pend      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mask  <= '0;
      busy      <= 1'b0;
    end else begin
      pend <= 1'b0;
      case (state)
        IDLE: begin
          if (seed_load) lfsr <= seed_eff;
          if (in_valid) begin
            data_q <= in_data;
            mask_q <= in_mask;
            enc_q  <= encrypt;
            cnt    <= 4'd0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          lfsr <= lfsr_next;
          if (PIPE) begin
            // Q and N are kept in separate registers, never combined.
            q_pipe   <= sb_q;
            n_pipe   <= sb_n;
            idx_pipe <= cnt;
            pend     <= 1'b1;
          end else begin
            out_data[{cnt, 3'b000} +: 8] <= sb_q;
            out_mask[{cnt, 3'b000} +: 8] <= sb_n;
          end
          if (cnt == 4'd15) begin
            cnt <= 4'd0;
            if (PIPE) begin
              state <= DRAIN;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DRAIN: begin
          state     <= DONE;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (PIPE && pend) begin
        out_data[{idx_pipe, 3'b000} +: 8] <= q_pipe;
        out_mask[{idx_pipe, 3'b000} +: 8] <= n_pipe;
      end
    end
  end
endmodule

// File: tb/tb_masked_sbox_sequencer.sv
// Bench for masked_sbox_sequencer: PIPE=0 (dut0) and PIPE=1 (dut1) against a
// table-driven S-box and LFSR reference model.

module tb_masked_sbox_sequencer;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   in_valid, in_ready, encrypt, seed_load, out_valid, out_ready, busy;
  logic [127:0] in_data [2];
  logic [127:0] in_mask [2];
  logic [127:0] out_data [2];
  logic [127:0] out_mask [2];
  logic [15:0]  seed [2];

  int total = 0;
  int bad = 0;
  logic [7:0]   sbox [256];
  logic [7:0]   isbox [256];
  logic [15:0]  mlfsr [2];
  logic [127:0] exp_data [2];
  logic [127:0] exp_mask [2];

  masked_sbox_sequencer #(.PIPE(1'b0), .RESET_SEED(16'hACE1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .encrypt(encrypt[0]), .in_data(in_data[0]), .in_mask(in_mask[0]),
    .seed_load(seed_load[0]), .seed(seed[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .out_mask(out_mask[0]),
    .busy(busy[0])
  );

  masked_sbox_sequencer #(.PIPE(1'b1), .RESET_SEED(16'hACE1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .encrypt(encrypt[1]), .in_data(in_data[1]), .in_mask(in_mask[1]),
    .seed_load(seed_load[1]), .seed(seed[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .out_mask(out_mask[1]),
    .busy(busy[1])
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] step(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Classic generator walk: p steps through powers of 3, q through powers of 1/3.
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
    for (int k = 0; k < 256; k++) isbox[sbox[k]] = 8'(k);
  endtask

  task automatic load_seed(input int s, input logic [15:0] sd);
    @(negedge clk);
    seed_load[s] = 1'b1;
    seed[s] = sd;
    @(posedge clk);
    #1;
    seed_load[s] = 1'b0;
    mlfsr[s] = (sd == 16'h0000) ? 16'hACE1 : sd;
  endtask

  task automatic send(input int s, input logic enc, input logic [127:0] d, input logic [127:0] m);
    int n = 0;
    logic [7:0] xb, nb;
    in_valid[s] = 1'b1;
    encrypt[s] = enc;
    in_data[s] = d;
    in_mask[s] = m;
    while (!in_ready[s] && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (in_ready[s] !== 1'b1) begin
      bad++;
      $display("FAIL accept dut%0d: in_ready=%b required 1", s, in_ready[s]);
    end
    @(posedge clk);
    #1;
    in_valid[s] = 1'b0;
    for (int b = 0; b < 16; b++) begin
      xb = d[8*b +: 8] ^ m[8*b +: 8];
      nb = mlfsr[s][7:0];
      exp_mask[s][8*b +: 8] = nb;
      exp_data[s][8*b +: 8] = (enc ? sbox[xb] : isbox[xb]) ^ nb;
      mlfsr[s] = step(mlfsr[s]);
    end
  endtask

  task automatic wait_out(input int s, input int pulse_at, input logic [15:0] pseed);
    int lat = 1;
    @(negedge clk);
    while (!out_valid[s] && lat < 40) begin
      if (lat == pulse_at) begin
        seed_load[s] = 1'b1;
        seed[s] = pseed;
      end else begin
        seed_load[s] = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    seed_load[s] = 1'b0;
    total++;
    if (lat != 17 + s) begin
      bad++;
      $display("FAIL latency dut%0d: got %0d required %0d", s, lat, 17 + s);
    end
    total++;
    if (out_mask[s] !== exp_mask[s]) begin
      bad++;
      $display("FAIL out_mask dut%0d: got %h required %h", s, out_mask[s], exp_mask[s]);
    end
    total++;
    if (out_data[s] !== exp_data[s]) begin
      bad++;
      $display("FAIL out_data dut%0d: got %h required %h", s, out_data[s], exp_data[s]);
    end
  endtask

  task automatic release_out(input int s);
    out_ready[s] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[s] = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid[s] !== 1'b0 || in_ready[s] !== 1'b1) begin
      bad++;
      $display("FAIL handoff dut%0d: out_valid=%b in_ready=%b required 0/1", s, out_valid[s], in_ready[s]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = '0; encrypt = '0; seed_load = '0; out_ready = '0;
    for (int s = 0; s < 2; s++) begin
      in_data[s] = '0; in_mask[s] = '0; seed[s] = '0; mlfsr[s] = 16'hACE1;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      total++;
      if (in_ready[s] !== 1'b0 || out_valid[s] !== 1'b0 || busy[s] !== 1'b0) begin
        bad++;
        $display("FAIL reset_ctl dut%0d: in_ready=%b out_valid=%b busy=%b required 0/0/0",
                 s, in_ready[s], out_valid[s], busy[s]);
      end
      total++;
      if (out_data[s] !== '0 || out_mask[s] !== '0) begin
        bad++;
        $display("FAIL reset_out dut%0d: data=%h mask=%h required 0", s, out_data[s], out_mask[s]);
      end
    end
    rst_n = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) begin
      total++;
      if (in_ready[s] !== 1'b1) begin
        bad++;
        $display("FAIL release_ready dut%0d: in_ready=%b required 1", s, in_ready[s]);
      end
    end
  endtask

  task automatic test_known();
    load_seed(0, 16'h0001);
    send(0, 1'b1, '0, '0);
    total++;
    if (busy[0] !== 1'b1) begin
      bad++;
      $display("FAIL busy_run: got %b required 1", busy[0]);
    end
    wait_out(0, 0, 16'h0000);
    total++;
    if (out_mask[0][7:0] !== 8'h01 || out_data[0][7:0] !== 8'h62) begin
      bad++;
      $display("FAIL known_b0: mask=%h data=%h required 01/62", out_mask[0][7:0], out_data[0][7:0]);
    end
    total++;
    if (out_mask[0][23:8] !== 16'h0000 || out_data[0][23:8] !== 16'h6363) begin
      bad++;
      $display("FAIL known_b12: mask=%h data=%h required 0000/6363", out_mask[0][23:8], out_data[0][23:8]);
    end
    release_out(0);
  endtask

  task automatic test_inverse();
    logic [127:0] m, r;
    for (int s = 0; s < 2; s++) begin
      m = rand128();
      send(s, 1'b0, m ^ {16{8'h63}}, m);
      wait_out(s, 0, 16'h0000);
      r = out_data[s] ^ out_mask[s];
      total++;
      if (r !== '0) begin
        bad++;
        $display("FAIL inverse_zero dut%0d: unmasked=%h required 0", s, r);
      end
      release_out(s);
    end
  endtask

  task automatic test_random(input int n);
    int s;
    for (int i = 0; i < n; i++) begin
      s = i % 2;
      send(s, 1'($urandom_range(0, 1)), rand128(), rand128());
      wait_out(s, 0, 16'h0000);
      release_out(s);
    end
  endtask

  task automatic test_seed();
    load_seed(1, 16'h0000);
    send(1, 1'b1, rand128(), rand128());
    wait_out(1, 0, 16'h0000);
    total++;
    if (out_mask[1][7:0] !== 8'hE1) begin
      bad++;
      $display("FAIL seed_zero: mask byte0=%h required e1", out_mask[1][7:0]);
    end
    release_out(1);
    // Pulsing seed_load mid-block must leave the modelled mask sequence intact.
    for (int s = 0; s < 2; s++) begin
      send(s, 1'($urandom_range(0, 1)), rand128(), rand128());
      wait_out(s, 8, 16'h1234);
      release_out(s);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] bd, bm;
    send(0, 1'b1, rand128(), rand128());
    wait_out(0, 0, 16'h0000);
    bd = rand128();
    bm = rand128();
    in_valid[0] = 1'b1;
    encrypt[0] = 1'b0;
    in_data[0] = bd;
    in_mask[0] = bm;
    for (int k = 0; k < 10; k++) begin
      total++;
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 ||
          out_data[0] !== exp_data[0] || out_mask[0] !== exp_mask[0]) begin
        bad++;
        $display("FAIL stall cycle %0d: out_valid=%b in_ready=%b data=%h required 1/0/%h",
                 k, out_valid[0], in_ready[0], out_data[0], exp_data[0]);
      end
      @(negedge clk);
    end
    release_out(0);
    send(0, 1'b0, bd, bm);
    wait_out(0, 0, 16'h0000);
    release_out(0);
  endtask

  task automatic test_reset_midrun();
    int seen = 0;
    send(0, 1'b1, rand128(), rand128());
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    mlfsr[0] = 16'hACE1;
    mlfsr[1] = 16'hACE1;
    total++;
    if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
      bad++;
      $display("FAIL abort: out_valid=%b busy=%b in_ready=%b required 0/0/0",
               out_valid[0], busy[0], in_ready[0]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (out_valid[0]) seen++;
    end
    total++;
    if (seen != 0 || in_ready[0] !== 1'b1) begin
      bad++;
      $display("FAIL post_abort: out_valid cycles=%0d in_ready=%b required 0/1", seen, in_ready[0]);
    end
    send(0, 1'b1, rand128(), rand128());
    wait_out(0, 0, 16'h0000);
    total++;
    if (out_mask[0][7:0] !== 8'hE1) begin
      bad++;
      $display("FAIL abort_seed: mask byte0=%h required e1", out_mask[0][7:0]);
    end
    release_out(0);
  endtask

  initial begin
    build_tables();
    test_reset();
    test_known();
    test_inverse();
    test_seed();
    test_back_to_back();
    test_reset_midrun();
    test_random(1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
